// File: rtl/bram_frame_ctrl.sv
// Frame BRAM sequencer: packs UART byte pairs into words on port A, drains them in order on port B.
// Latency: write in the cycle of the second byte; drained word appears RD_LAT+1 cycles after its read issue.
// Backpressure: out_data held until out_ready; bytes arriving while full or draining are dropped (sticky overflow).
module bram_frame_ctrl #(
    parameter int ADDR_W    = 12,
    parameter int DEPTH     = 4096,
    parameter int RD_LAT    = 1,
    parameter int LSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              rd_start,
    input  logic              clear,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [15:0]       dina,
    output logic              enb,
    output logic [ADDR_W-1:0] addrb,
    input  logic [15:0]       doutb,
    output logic [15:0]       out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W:0]   word_count,
    output logic              full,
    output logic              overflow,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_RD_ISSUE = 2'd1;
    localparam logic [1:0] S_RD_WAIT  = 2'd2;
    localparam logic [1:0] S_RD_OUT   = 2'd3;

    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic [1:0]        state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   word_count_q;
    logic              half;
    logic [7:0]        first_byte;
    logic [LAT_W-1:0]  wait_cnt;
    logic [15:0]       out_data_q;
    logic              overflow_q;
    logic              done_q;

    logic        is_idle;
    logic        full_c;
    logic        wr_fire;
    logic        drop;
    logic        start_ok;
    logic        last_word;
    logic        wait_last;
    logic [15:0] pair;

    assign is_idle   = (state == S_IDLE);
    assign full_c    = (word_count_q == DEPTH_C);
    assign wr_fire   = rx_valid && is_idle && !full_c && half && !clear;
    assign drop      = rx_valid && (!is_idle || full_c);
    assign pair      = (LSB_FIRST != 0) ? {rx_data, first_byte} : {first_byte, rx_data};
    // A second byte landing with rd_start counts toward the drain length.
    assign start_ok  = rd_start && is_idle && ((word_count_q != '0) || wr_fire);
    assign last_word = ({1'b0, rd_ptr} == (word_count_q - (ADDR_W+1)'(1)));
    assign wait_last = (wait_cnt == LAT_W'(RD_LAT - 1));

    assign wea        = wr_fire;
    assign addra      = wr_ptr;
    assign dina       = wr_fire ? pair : 16'h0000;
    assign enb        = (state == S_RD_ISSUE);
    assign addrb      = rd_ptr;
    assign out_data   = out_data_q;
    assign out_valid  = (state == S_RD_OUT);
    assign word_count = word_count_q;
    assign full       = full_c;
    assign overflow   = overflow_q;
    assign busy       = !is_idle;
    assign done       = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            word_count_q <= '0;
            half         <= 1'b0;
            first_byte   <= 8'h00;
            wait_cnt     <= '0;
            out_data_q   <= 16'h0000;
            overflow_q   <= 1'b0;
            done_q       <= 1'b0;
        end else if (clear) begin
            state        <= S_IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            word_count_q <= '0;
            half         <= 1'b0;
            first_byte   <= 8'h00;
            wait_cnt     <= '0;
            out_data_q   <= 16'h0000;
            overflow_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (drop) begin
                overflow_q <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (rx_valid && !full_c) begin
                        half <= ~half;
                        if (!half) begin
                            first_byte <= rx_data;
                        end
                    end
                    if (wr_fire) begin
                        wr_ptr       <= wr_ptr + ADDR_W'(1);
                        word_count_q <= word_count_q + (ADDR_W+1)'(1);
                    end
                    // Starting a drain discards any lone pending byte.
                    if (start_ok) begin
                        half   <= 1'b0;
                        rd_ptr <= '0;
                        state  <= S_RD_ISSUE;
                    end
                end
                S_RD_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (wait_last) begin
                        out_data_q <= doutb;
                        state      <= S_RD_OUT;
                    end else begin
                        wait_cnt <= wait_cnt + LAT_W'(1);
                    end
                end
                S_RD_OUT: begin
                    if (out_ready) begin
                        if (last_word) begin
                            word_count_q <= '0;
                            wr_ptr       <= '0;
                            done_q       <= 1'b1;
                            state        <= S_IDLE;
                        end else begin
                            rd_ptr <= rd_ptr + ADDR_W'(1);
                            state  <= S_RD_ISSUE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_frame_ctrl.sv
// Directed bench for bram_frame_ctrl with a behavioural BRAM and a drain scoreboard.
// Main instance uses DEPTH=8 to reach full quickly; a second instance checks MSB-first packing.
module tb_bram_frame_ctrl;

    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rd_start;
    logic              clear;
    logic              out_ready;
    logic [15:0]       doutb;

    logic              wea, enb, out_valid, full, overflow, busy, done;
    logic [ADDR_W-1:0] addra, addrb;
    logic [15:0]       dina, out_data;
    logic [ADDR_W:0]   word_count;

    logic              wea1, enb1, out_valid1, full1, overflow1, busy1, done1;
    logic [ADDR_W-1:0] addra1, addrb1;
    logic [15:0]       dina1, out_data1;
    logic [ADDR_W:0]   word_count1;

    always #5 clk = ~clk;

    bram_frame_ctrl #(.ADDR_W(ADDR_W), .DEPTH(8), .RD_LAT(1), .LSB_FIRST(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .rd_start(rd_start), .clear(clear), .wea(wea), .addra(addra), .dina(dina),
        .enb(enb), .addrb(addrb), .doutb(doutb), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .word_count(word_count),
        .full(full), .overflow(overflow), .busy(busy), .done(done)
    );

    bram_frame_ctrl #(.ADDR_W(ADDR_W), .DEPTH(8), .RD_LAT(1), .LSB_FIRST(0)) u_msb (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .rd_start(1'b0), .clear(clear), .wea(wea1), .addra(addra1), .dina(dina1),
        .enb(enb1), .addrb(addrb1), .doutb(16'h0000), .out_data(out_data1),
        .out_valid(out_valid1), .out_ready(1'b1), .word_count(word_count1),
        .full(full1), .overflow(overflow1), .busy(busy1), .done(done1)
    );

    // Behavioural 4096x16 BRAM, one-cycle read latency on port B.
    logic [15:0] mem [0:4095];
    always @(posedge clk) begin
        if (wea) mem[addra] <= dina;
        if (enb) doutb <= mem[addrb];
    end

    int          cyc = 0;
    int          wea_cnt = 0;
    int          done_cnt = 0;
    logic [15:0] last_dina = 16'h0;
    logic [15:0] last_dina1 = 16'h0;
    logic [ADDR_W-1:0] last_addra = '0;
    logic [ADDR_W-1:0] enb_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wea) begin
            wea_cnt    <= wea_cnt + 1;
            last_dina  <= dina;
            last_addra <= addra;
        end
        if (wea1) last_dina1 <= dina1;
        if (enb) enb_q.push_back(addrb);
        if (done) done_cnt <= done_cnt + 1;
    end

    int          passed = 0;
    int          failed = 0;
    int          total = 0;
    logic [15:0] sb [$];
    int          hs_cyc [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w);
        send_byte(w[7:0]);
        send_byte(w[15:8]);
        sb.push_back(w);
    endtask

    task automatic pulse_start();
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        sb.delete();
    endtask

    // Pops the scoreboard on each handshake; ends at posedge+1 after the last one.
    task automatic collect(input int n);
        int          waited;
        logic [15:0] exp;
        for (int k = 0; k < n; k++) begin
            waited = 0;
            @(negedge clk);
            while (!(out_valid && out_ready) && waited < 50) begin
                @(negedge clk);
                waited++;
            end
            if (waited >= 50) begin
                chk("drain_timeout", {31'b0, out_valid}, 32'd1);
                return;
            end
            exp = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
            chk("drain_data", {16'b0, out_data}, {16'b0, exp});
            hs_cyc.push_back(cyc);
            tick();
        end
    endtask

    task automatic wait_valid();
        int waited;
        waited = 0;
        @(negedge clk);
        while (!out_valid && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("wait_valid", {31'b0, out_valid}, 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_w, base_e, base_d, base_h;
        rst_n = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; rd_start = 1'b0;
        clear = 1'b0; out_ready = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_flags", {25'b0, wea, enb, out_valid, full, overflow, busy, done}, 32'd0);
        chk("rst_word_count", {19'b0, word_count}, 32'd0);
        chk("rst_out_data", {16'b0, out_data}, 32'd0);
        chk("rst_dina", {16'b0, dina}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Packing, both byte orders
        base_w = wea_cnt;
        send_byte(8'h34);
        chk("pack_no_early_write", wea_cnt - base_w, 32'd0);
        send_byte(8'h12);
        chk("pack_wea_pulses", wea_cnt - base_w, 32'd1);
        chk("pack_addra", {20'b0, last_addra}, 32'd0);
        chk("pack_dina_lsb", {16'b0, last_dina}, 32'h1234);
        chk("pack_dina_msb", {16'b0, last_dina1}, 32'h3412);
        chk("pack_word_count", {19'b0, word_count}, 32'd1);
        do_clear();
        chk("clear_word_count", {19'b0, word_count}, 32'd0);

        // Drain with out_ready held high
        send_word(16'h1111); send_word(16'h2222); send_word(16'h3333);
        out_ready = 1'b1;
        base_e = enb_q.size(); base_d = done_cnt; base_h = hs_cyc.size();
        pulse_start();
        chk("drain_busy", {31'b0, busy}, 32'd1);
        collect(3);
        tick(); tick();
        chk("drain_spacing1", hs_cyc[base_h+1] - hs_cyc[base_h], 32'd3);
        chk("drain_spacing2", hs_cyc[base_h+2] - hs_cyc[base_h+1], 32'd3);
        chk("drain_enb_count", enb_q.size() - base_e, 32'd3);
        for (int i = 0; i < 3; i++) chk("drain_addrb", {20'b0, enb_q[base_e+i]}, i);
        chk("drain_done_once", done_cnt - base_d, 32'd1);
        chk("drain_word_count", {19'b0, word_count}, 32'd0);
        chk("drain_busy_after", {31'b0, busy}, 32'd0);

        // Backpressure on the second word
        send_word(16'h1111); send_word(16'h2222); send_word(16'h3333);
        pulse_start();
        collect(1);
        out_ready = 1'b0;
        wait_valid();
        base_e = enb_q.size();
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_data", {16'b0, out_data}, 32'h2222);
            @(negedge clk);
        end
        chk("bp_no_enb", enb_q.size() - base_e, 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        collect(2);
        tick();
        chk("bp_busy_after", {31'b0, busy}, 32'd0);

        // Byte arriving during a drain
        do_clear();
        send_word(16'hA1B2); send_word(16'hC3D4);
        chk("ovf_clear", {31'b0, overflow}, 32'd0);
        pulse_start();
        base_w = wea_cnt;
        send_byte(8'h55);
        chk("busy_drop_overflow", {31'b0, overflow}, 32'd1);
        chk("busy_drop_no_write", wea_cnt - base_w, 32'd0);
        collect(2);
        tick();

        // Fill to DEPTH=8 with 18 bytes
        do_clear();
        base_w = wea_cnt;
        for (int i = 0; i < 9; i++) begin
            logic [15:0] w;
            w = {8'(2*i + 8'h81), 8'(2*i + 8'h40)};
            if (i == 7) chk("not_full_at_7", {31'b0, full}, 32'd0);
            if (i < 8) send_word(w);
            else begin
                send_byte(w[7:0]);
                send_byte(w[15:8]);
            end
        end
        chk("full_wea_pulses", wea_cnt - base_w, 32'd8);
        chk("full_flag", {31'b0, full}, 32'd1);
        chk("full_overflow", {31'b0, overflow}, 32'd1);
        chk("full_word_count", {19'b0, word_count}, 32'd8);
        pulse_start();
        collect(8);
        tick();
        chk("full_drained", {19'b0, word_count}, 32'd0);

        // rd_start with nothing stored
        do_clear();
        pulse_start();
        @(negedge clk);
        chk("empty_start_busy", {31'b0, busy}, 32'd0);
        @(posedge clk); #1;

        // rd_start together with the second byte
        send_byte(8'hAA);
        rx_data = 8'hBB; rx_valid = 1'b1; rd_start = 1'b1;
        tick();
        rx_valid = 1'b0; rd_start = 1'b0;
        sb.push_back(16'hBBAA);
        chk("same_cycle_busy", {31'b0, busy}, 32'd1);
        collect(1);
        tick();
        chk("same_cycle_idle", {31'b0, busy}, 32'd0);

        // Lone pending byte is discarded by rd_start
        send_word(16'h4321);
        send_byte(8'h99);
        pulse_start();
        collect(1);
        tick(); tick();
        send_word(16'h6655);
        chk("pending_discard_dina", {16'b0, last_dina}, 32'h6655);
        chk("pending_discard_count", {19'b0, word_count}, 32'd1);

        // Asynchronous reset while in RD_OUT
        out_ready = 1'b0;
        pulse_start();
        wait_valid();
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("arst_word_count", {19'b0, word_count}, 32'd0);
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_out_data", {16'b0, out_data}, 32'd0);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        chk("arst_idle_after", {30'b0, busy, out_valid}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/bram_frame_ctrl.md
Name: bram_frame_ctrl

Overview:
- Sequencer for the 4096x16 dual-port frame BRAM.
- Fill: takes the UART receive byte stream, packs byte pairs into 16-bit words and writes them to sequential BRAM addresses on port A.
- Drain: on command, reads the stored words back on port B in address order and presents them on a valid/ready stream to the downstream consumer.
- Reports word count, full, overflow and completion.

Parameters:
- ADDR_W, 12, BRAM address width.
- DEPTH, 4096, word capacity; must be <= 2**ADDR_W.
- RD_LAT, 1, BRAM port-B read latency in cycles; must be >= 1.
- LSB_FIRST, 1, 1 = first byte of a pair is bits [7:0]; 0 = first byte is bits [15:8].

Ports:
- clk  in  1  single clock; also drives BRAM clka and clkb.
- rst_n  in  1  asynchronous active-low reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe, rx_data valid.
- rd_start  in  1  one-cycle drain command.
- clear  in  1  synchronous flush of pointers, flags and state.
- wea  out  1  BRAM port-A write enable.
- addra  out  ADDR_W  BRAM port-A address.
- dina  out  16  BRAM port-A write data.
- enb  out  1  BRAM port-B read enable.
- addrb  out  ADDR_W  BRAM port-B address.
- doutb  in  16  BRAM port-B read data.
- out_data  out  16  drained word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts out_data.
- word_count  out  ADDR_W+1  words stored.
- full  out  1  word_count == DEPTH.
- overflow  out  1  sticky: a byte was dropped.
- busy  out  1  drain in progress (state != IDLE).
- done  out  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset (rst_n low, asynchronous) and clear (synchronous) both force:
  - state IDLE, all pointers 0, byte-half flag 0;
  - every output 0.
- States: IDLE, RD_ISSUE, RD_WAIT, RD_OUT.
- IDLE, byte packing:
  - Each rx_valid toggles the half flag. The first byte is latched.
  - On the second byte: wea=1 for exactly that cycle, addra=wr_ptr, dina={second,first} when LSB_FIRST=1, else {first,second}.
  - wr_ptr and word_count increment at the end of that cycle.
- Full:
  - While full=1, rx_valid bytes are dropped, overflow is set and no write occurs.
  - A pending first byte when full is reached is discarded.
- Leaving IDLE:
  - rd_start with word_count==0: ignored.
  - rd_start with word_count>0: clear the half flag (a lone pending byte is discarded), set rd_ptr=0, go to RD_ISSUE.
  - rd_start in the same cycle as a second byte: the write completes first and the drain includes that word.
- RD_ISSUE: enb=1, addrb=rd_ptr for one cycle -> RD_WAIT.
- RD_WAIT:
  - Lasts RD_LAT cycles.
  - On its last cycle, doutb is registered into out_data -> RD_OUT.
  - out_valid rises on the first cycle of RD_OUT.
- RD_OUT:
  - out_valid=1. out_data is held stable until out_ready=1.
  - On the handshake, out_valid drops the next cycle.
  - If rd_ptr == word_count-1: word_count=0, wr_ptr=0, done pulses, next state IDLE.
  - Otherwise rd_ptr++ and next state RD_ISSUE.
- Throughput with out_ready held high: one word every RD_LAT+2 cycles.
- While busy: rx_valid bytes are dropped and overflow is set. wea stays 0.
- overflow clears only on reset or clear.
- Reset or clear mid-drain: state returns to IDLE immediately; the stream is abandoned; out_valid=0 in the next cycle.
- BRAM contents are never cleared; word_count alone defines valid data.

Test Plan:
- Reset check: assert rst_n=0 mid-cycle -> all outputs 0 asynchronously; state IDLE after release.
- Packing: bytes 0x34 then 0x12 (LSB_FIRST=1) -> single wea pulse, addra=0, dina=0x1234, word_count=1.
  - Repeat with LSB_FIRST=0 -> dina=0x3412.
- Drain: store 0x1111, 0x2222, 0x3333; rd_start with out_ready=1 -> out_data sequence 0x1111, 0x2222, 0x3333.
  - Each word 3 cycles apart (RD_LAT=1), with addrb 0,1,2 on the enb cycles.
  - done pulses once; word_count=0 and busy=0 afterwards.
- Backpressure: hold out_ready=0 for 10 cycles on word 2 -> out_valid=1 and out_data=0x2222 stable; no further enb until the handshake.
- Overflow: DEPTH=8, send 18 bytes -> exactly 8 wea pulses, full=1, overflow=1.
  - Send a byte during a drain -> overflow=1 and wea stays 0.
- Corner cases:
  - rd_start with word_count=0 -> busy stays 0.
  - rd_start together with a second byte -> the drain includes that word.
  - Drop rst_n during RD_OUT -> out_valid=0, word_count=0, state IDLE.
